// File: rtl/ps2_scancode_rx_pkg.sv
// ps2_scancode_rx_pkg
// Shared definitions for the PS/2 scancode receiver: prefix bytes, keyboard
// overrun codes, FSM state encoding and the frame parity helper.
package ps2_scancode_rx_pkg;

    // Prefix bytes that modify the following scancode.
    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

    // Bytes a keyboard sends when its internal buffer overruns.
    localparam logic [7:0] PS2_OVERRUN_LO = 8'h00;
    localparam logic [7:0] PS2_OVERRUN_HI = 8'hFF;

    // Frame receive states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // True when data bits plus parity bit hold an odd number of ones.
    function automatic logic ps2_parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge
// Brings the asynchronous PS/2 clock and data pins into the clk domain through
// two clk_en-qualified flops each and flags falling edges of the PS/2 clock.
// Ports:
//   clk        system clock
//   nRESET     synchronous active-low reset (synchronisers reset to 1)
//   clk_en     advance enable; nothing but reset changes while low
//   ps2_clk_i  raw PS/2 clock pin
//   ps2_data_i raw PS/2 data pin
//   fall_o     high on the enabled cycle where the synchronised clock went 1 -> 0
//   data_o     synchronised data, valid to sample when fall_o is high
module ps2_sync_edge (
    input  logic clk,
    input  logic nRESET,
    input  logic clk_en,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);

    logic [1:0] clk_sync_q;
    logic [1:0] data_sync_q;
    logic       clk_prev_q;   // synchronised clock as seen on the previous enabled cycle

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else if (clk_en) begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    // Clock and data share the same synchroniser depth, so data_o lines up
    // with the clock sample that produced the edge.
    assign fall_o = clk_en & clk_prev_q & ~clk_sync_q[1];
    assign data_o = data_sync_q[1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
// Receives PS/2 keyboard frames, strips E0/F0 prefixes and presents one
// {extended, release, code} event at a time through a valid/ready register.
// Ports:
//   clk        system clock
//   nRESET     synchronous active-low reset
//   clk_en     advance enable; nothing but reset changes while low
//   PS2_CLK    raw PS/2 clock pin
//   PS2_DATA   raw PS/2 data pin
//   ready      consumer accepts the held event
//   valid      an event is held in the output register
//   code       scancode byte with prefixes removed
//   extended   event was preceded by E0
//   release_o  event was preceded by F0 (key up); `release` is a reserved word
//   error      one-enabled-cycle pulse on a frame fault, overrun code or timeout
//   overflow   one-enabled-cycle pulse when an event is dropped
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int TIMEOUT = 2000
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       ready,
    output logic       valid,
    output logic [7:0] code,
    output logic       extended,
    output logic       release_o,
    output logic       error,
    output logic       overflow
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    logic fall;
    logic sdata;

    ps2_sync_edge u_sync_edge (
        .clk        (clk),
        .nRESET     (nRESET),
        .clk_en     (clk_en),
        .ps2_clk_i  (PS2_CLK),
        .ps2_data_i (PS2_DATA),
        .fall_o     (fall),
        .data_o     (sdata)
    );

    ps2_state_e    state_q,   state_d;
    logic [2:0]    bitcnt_q,  bitcnt_d;
    logic [7:0]    shift_q,   shift_d;
    logic          par_ok_q,  par_ok_d;
    logic          ext_q,     ext_d;
    logic          rel_q,     rel_d;
    logic [TW-1:0] tmo_q,     tmo_d;
    logic          valid_q,   valid_d;
    logic [7:0]    code_q,    code_d;
    logic          ext_out_q, ext_out_d;
    logic          rel_out_q, rel_out_d;
    logic          error_q,   error_d;
    logic          ovf_q,     ovf_d;
    logic          fault;
    logic          emit;

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        ext_d     = ext_q;
        rel_d     = rel_q;
        tmo_d     = tmo_q;
        valid_d   = valid_q;
        code_d    = code_q;
        ext_out_d = ext_out_q;
        rel_out_d = rel_out_q;
        error_d   = 1'b0;
        ovf_d     = 1'b0;
        fault     = 1'b0;
        emit      = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    if (!sdata) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        // Edge without a start bit: flag it, prefixes survive.
                        error_d = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (fall) begin
                    shift_d  = {sdata, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (fall) begin
                    par_ok_d = ps2_parity_ok({sdata, shift_q});
                    state_d  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    if (sdata && par_ok_q) begin
                        if (shift_q == PS2_PREFIX_EXT) begin
                            ext_d = 1'b1;
                        end else if (shift_q == PS2_PREFIX_REL) begin
                            rel_d = 1'b1;
                        end else if (shift_q == PS2_OVERRUN_LO || shift_q == PS2_OVERRUN_HI) begin
                            fault = 1'b1;
                        end else begin
                            emit = 1'b1;
                        end
                    end else begin
                        fault = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog on a stalled frame; an edge always restarts it, and the
        // compare stops it at TIMEOUT so it cannot wrap.
        if (state_q == ST_IDLE || fall) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_LIMIT) begin
            tmo_d   = '0;
            state_d = ST_IDLE;
            fault   = 1'b1;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end

        if (fault) begin
            error_d = 1'b1;
            ext_d   = 1'b0;
            rel_d   = 1'b0;
        end

        // A held event that is not being accepted this cycle wins over the
        // new one; acceptance in the same cycle frees the register.
        if (emit) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
            if (valid_q && !ready) begin
                ovf_d = 1'b1;
            end else begin
                valid_d   = 1'b1;
                code_d    = shift_q;
                ext_out_d = ext_q;
                rel_out_d = rel_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= 3'd0;
            shift_q   <= 8'h00;
            par_ok_q  <= 1'b0;
            ext_q     <= 1'b0;
            rel_q     <= 1'b0;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            code_q    <= 8'h00;
            ext_out_q <= 1'b0;
            rel_out_q <= 1'b0;
            error_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (clk_en) begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            ext_q     <= ext_d;
            rel_q     <= rel_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            ext_out_q <= ext_out_d;
            rel_out_q <= rel_out_d;
            error_q   <= error_d;
            ovf_q     <= ovf_d;
        end
    end

    assign valid     = valid_q;
    assign code      = code_q;
    assign extended  = ext_out_q;
    assign release_o = rel_out_q;
    assign error     = error_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

    localparam int TIMEOUT = 40;
    localparam int HALF    = 8;   // clk cycles per PS/2 clock half period

    logic       clk      = 1'b0;
    logic       nRESET   = 1'b0;
    logic       clk_en   = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       ready    = 1'b0;
    logic       valid;
    logic [7:0] code;
    logic       extended;
    logic       rel_o;
    logic       error;
    logic       overflow;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       rel;
    } ev_t;

    ev_t exp_q[$];
    int  n_cmp    = 0;
    int  n_bad    = 0;
    int  err_seen = 0;
    int  ovf_seen = 0;
    int  exp_err  = 0;
    int  exp_ovf  = 0;

    ps2_scancode_rx #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .nRESET    (nRESET),
        .clk_en    (clk_en),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .ready     (ready),
        .valid     (valid),
        .code      (code),
        .extended  (extended),
        .release_o (rel_o),
        .error     (error),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // clk_en alternates so every enabled cycle spans two clk cycles.
    always @(posedge clk) begin
        #1 clk_en = ~clk_en;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: counts pulses and checks every accepted event against the queue.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (nRESET && clk_en) begin
                if (error)    err_seen++;
                if (overflow) ovf_seen++;
                if (valid && ready) begin
                    $display("event code=%h ext=%b rel=%b", code, extended, rel_o);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_event: got code=%h ext=%b rel=%b, expected none",
                                 code, extended, rel_o);
                    end else begin
                        e = exp_q.pop_front();
                        check("event", 32'({code, extended, rel_o}), 32'(e));
                    end
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DATA = b;
        wait_clks(HALF);
        PS2_CLK = 1'b0;
        wait_clks(HALF);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(stp);
        PS2_DATA = 1'b1;
        wait_clks(4 * HALF);
    endtask

    task automatic expect_ev(input logic [7:0] c, input logic e, input logic r);
        ev_t ev;
        ev.code = c;
        ev.ext  = e;
        ev.rel  = r;
        exp_q.push_back(ev);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            wait_clks(1);
            n++;
        end
        check({name, "_pending"}, 32'(exp_q.size()), 0);
        wait_clks(4);
        check({name, "_errors"}, 32'(err_seen), 32'(exp_err));
        check({name, "_overflows"}, 32'(ovf_seen), 32'(exp_ovf));
    endtask

    initial begin
        nRESET = 1'b0;
        wait_clks(6);
        check("rst_valid",    32'(valid),    0);
        check("rst_code",     32'(code),     0);
        check("rst_extended", 32'(extended), 0);
        check("rst_release",  32'(rel_o),    0);
        check("rst_error",    32'(error),    0);
        check("rst_overflow", 32'(overflow), 0);
        nRESET = 1'b1;
        ready  = 1'b1;
        wait_clks(4);

        // Plain make code.
        expect_ev(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("make_1c");

        // Break code.
        expect_ev(8'h1C, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("break_1c");

        // Extended break, then flags must be clear again.
        expect_ev(8'h75, 1'b1, 1'b1);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h75, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("ext_break_75");

        // Bad parity, then a good frame.
        exp_err++;
        expect_ev(8'h1B, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1B, 1'b1, 1'b1);
        drain("bad_parity");

        // Five bits, then the PS/2 clock stalls high.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        wait_clks(2 * (TIMEOUT + 5));
        PS2_DATA = 1'b1;
        exp_err++;
        check("timeout_errors", 32'(err_seen), 32'(exp_err));
        expect_ev(8'h29, 1'b0, 1'b0);
        send_frame(8'h29, 1'b0, 1'b1);
        drain("after_timeout");

        // Overrun codes fault and wipe a pending E0.
        exp_err += 2;
        expect_ev(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("overrun");

        // Bad stop bit faults and wipes a pending F0.
        exp_err++;
        expect_ev(8'h1B, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1B, 1'b1, 1'b1);
        drain("bad_stop");

        // Falling edge in idle without a start bit.
        exp_err++;
        ps2_bit(1'b1);
        wait_clks(2 * HALF);
        drain("idle_no_start");

        // Back-pressure: second event is dropped.
        ready = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b1);
        check("hold_valid", 32'(valid), 1);
        check("hold_code",  32'(code),  32'h1C);
        exp_ovf++;
        send_frame(8'h1B, 1'b1, 1'b1);
        check("ovf_valid",  32'(valid), 1);
        check("ovf_code",   32'(code),  32'h1C);
        check("ovf_pulses", 32'(ovf_seen), 32'(exp_ovf));
        expect_ev(8'h1C, 1'b0, 1'b0);
        ready = 1'b1;
        drain("overflow");
        check("ovf_valid_low", 32'(valid), 0);

        // Reset mid-frame; the next frame decodes cleanly.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        nRESET = 1'b0;
        wait_clks(4);
        nRESET = 1'b1;
        PS2_DATA = 1'b1;
        wait_clks(4);
        expect_ev(8'h1C, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b1);
        drain("mid_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
